addr_window_monitor: RTL and testbench

ADDR_WINDOW_MONITOR -- requirements
Module: addr_window_monitor

---
 rtl/addr_window_monitor.sv | 135 +++++++++++++
 tb/tb_addr_window_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_window_monitor.sv
// addr_window_monitor
// Watches the look-ahead memory bus for accesses that fall into up to four
// address windows. It produces a registered hit pulse per window, a registered
// write-hit strobe, a saturating hit counter per window and a sticky interrupt.
// The interrupt is raised when any counter reaches THRESHOLD.
//
// Build option: define ADDR_MON_READ_EN to let read strobes (mem_la_read)
// qualify matches as well as writes. When it is undefined, only writes
// qualify. mem_la_read stays on the port list so the pinout does not change.

module addr_window_monitor #(
   parameter int                            NUM_WIN   = 4,
   parameter int                            ADDR_W    = 32,
   parameter int                            CNT_W     = 16,
   parameter logic [NUM_WIN*ADDR_W-1:0]     WIN_BASE  = {32'h0, 32'h0, 32'h0, 32'h00001000},
   parameter logic [NUM_WIN*ADDR_W-1:0]     WIN_LIMIT = {32'h0, 32'h0, 32'h0, 32'h00004000},
   parameter int                            THRESHOLD = 100
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                mem_la_write,
   input  logic                mem_la_read,
   input  logic [ADDR_W-1:0]   mem_la_addr,
   input  logic                clr,
   input  logic                irq_ack,
   input  logic [1:0]          cnt_sel,
   output logic [NUM_WIN-1:0]  hit,
   output logic                out_byte_en,
   output logic [CNT_W-1:0]    cnt_val,
   output logic                irq
);

   // The threshold can only be reached by an increment if it lies in
   // 1 .. 2**CNT_W-1. A zero threshold is never "become equal" to.
   localparam longint          CNT_MAX_L = (longint'(1) << CNT_W) - 1;
   localparam bit              THR_OK    = (THRESHOLD >= 1) && (longint'(THRESHOLD) <= CNT_MAX_L);
   localparam logic [CNT_W-1:0] THR_M1   = THR_OK ? CNT_W'(THRESHOLD - 1) : '0;

   logic                w_qual;
   logic [NUM_WIN-1:0]  w_match;
   logic [NUM_WIN-1:0]  w_wmatch;
   logic [NUM_WIN-1:0]  w_set;
   logic [CNT_W-1:0]    w_cnt_tab [0:3];

   logic [NUM_WIN-1:0]  r_hit;
   logic                r_obe;
   logic                r_irq;

   // Strobe qualification: writes always, reads only in the read-enabled build.
`ifdef ADDR_MON_READ_EN
   assign w_qual = mem_la_write | mem_la_read;
`else
   logic w_unused_read;
   assign w_qual        = mem_la_write;
   assign w_unused_read = mem_la_read;
`endif

   // One slice per possible window. Unused slots read back as zero so that
   // cnt_sel can index a fixed four-entry table.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_win
         if (gi < NUM_WIN) begin : g_on
            localparam logic [ADDR_W-1:0] BASE  = WIN_BASE [gi*ADDR_W +: ADDR_W];
            localparam logic [ADDR_W-1:0] LIMIT = WIN_LIMIT[gi*ADDR_W +: ADDR_W];

            logic             w_in_range;
            logic [CNT_W-1:0] r_cnt;

            if (BASE < LIMIT) begin : g_en
               // Half-open range test done as a single unsigned compare:
               // addresses below BASE wrap to a large offset and fail.
               localparam logic [ADDR_W-1:0] SPAN = LIMIT - BASE;
               logic [ADDR_W-1:0] w_off;
               assign w_off      = mem_la_addr - BASE;
               assign w_in_range = (w_off < SPAN);
            end else begin : g_dis
               // Empty or inverted window: permanently disabled.
               assign w_in_range = 1'b0;
            end

            assign w_match[gi]  = w_qual & w_in_range;
            assign w_wmatch[gi] = mem_la_write & w_in_range;

            // This edge takes the counter from THRESHOLD-1 to THRESHOLD.
            // A clear on the same edge suppresses the increment, and
            // therefore the interrupt as well.
            assign w_set[gi] = THR_OK && w_match[gi] && !clr && (r_cnt == THR_M1);

            // Saturating hit counter; clear has priority over counting.
            always_ff @(posedge clk or negedge resetn) begin
               if (!resetn) begin
                  r_cnt <= '0;
               end else if (clr) begin
                  r_cnt <= '0;
               end else if (w_match[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            assign w_cnt_tab[gi] = r_cnt;
         end else begin : g_off
            assign w_cnt_tab[gi] = '0;
         end
      end
   endgenerate

   // Register per-window hit pulses and the write-hit strobe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hit <= '0;
         r_obe <= 1'b0;
      end else begin
         r_hit <= w_match;
         r_obe <= |w_wmatch;
      end
   end

   // Sticky interrupt; a new threshold crossing beats a same-edge ack.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_irq <= 1'b0;
      end else if (|w_set) begin
         r_irq <= 1'b1;
      end else if (irq_ack) begin
         r_irq <= 1'b0;
      end
   end

   assign hit         = r_hit;
   assign out_byte_en = r_obe;
   assign irq         = r_irq;
   assign cnt_val     = w_cnt_tab[cnt_sel];

endmodule

// File: tb/tb_addr_window_monitor.sv
// Testbench for addr_window_monitor: directed corner cases followed by a
// randomized burst, checked every cycle against a window/counter model.
`timescale 1ns/1ps

module tb_addr_window_monitor;

   localparam int NW   = 4;
   localparam int AW   = 32;
   localparam int CW   = 4;
   localparam int THR  = 15;
   localparam int CMAX = 15;

   // Window 0 = [0x1000,0x4000), 1 = [0x2000,0x3000) nested inside it,
   // 2 = empty (disabled), 3 = [0x8000,0x9000)
   localparam logic [31:0] BASE_A  [4] = '{32'h1000, 32'h2000, 32'h5000, 32'h8000};
   localparam logic [31:0] LIMIT_A [4] = '{32'h4000, 32'h3000, 32'h5000, 32'h9000};
   localparam logic [NW*AW-1:0] P_BASE  = {32'h8000, 32'h5000, 32'h2000, 32'h1000};
   localparam logic [NW*AW-1:0] P_LIMIT = {32'h9000, 32'h5000, 32'h3000, 32'h4000};

   logic          clk = 1'b0;
   logic          resetn;
   logic          mem_la_write, mem_la_read;
   logic [AW-1:0] mem_la_addr;
   logic          clr, irq_ack;
   logic [1:0]    cnt_sel;
   logic [NW-1:0] hit;
   logic          out_byte_en;
   logic [CW-1:0] cnt_val;
   logic          irq;

   int checks = 0;
   int errors = 0;

   addr_window_monitor #(
      .NUM_WIN(NW), .ADDR_W(AW), .CNT_W(CW),
      .WIN_BASE(P_BASE), .WIN_LIMIT(P_LIMIT), .THRESHOLD(THR)
   ) dut (
      .clk(clk), .resetn(resetn),
      .mem_la_write(mem_la_write), .mem_la_read(mem_la_read), .mem_la_addr(mem_la_addr),
      .clr(clr), .irq_ack(irq_ack), .cnt_sel(cnt_sel),
      .hit(hit), .out_byte_en(out_byte_en), .cnt_val(cnt_val), .irq(irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit in_win(input int k, input logic [31:0] a);
      return (BASE_A[k] < LIMIT_A[k]) && (a >= BASE_A[k]) && (a < LIMIT_A[k]);
   endfunction

   function automatic bit strobe_ok();
`ifdef ADDR_MON_READ_EN
      return mem_la_write || mem_la_read;
`else
      return mem_la_write;
`endif
   endfunction

   function automatic bit any_write_hit();
      bit r = 0;
      for (int k = 0; k < NW; k++) if (in_win(k, mem_la_addr)) r = 1;
      return r && mem_la_write;
   endfunction

   function automatic logic [NW-1:0] hit_vec();
      logic [NW-1:0] v = '0;
      for (int k = 0; k < NW; k++) v[k] = strobe_ok() && in_win(k, mem_la_addr);
      return v;
   endfunction

   logic [NW-1:0] exp_hit;
   logic          exp_obe;
   logic          exp_irq;
   int            exp_cnt [4];

   function automatic int next_cnt(input int k);
      if (clr) return 0;
      if (strobe_ok() && in_win(k, mem_la_addr)) return (exp_cnt[k] + 1 > CMAX) ? CMAX : exp_cnt[k] + 1;
      return exp_cnt[k];
   endfunction

   function automatic bit reaches_thr();
      bit r = 0;
      for (int k = 0; k < NW; k++)
         if (exp_cnt[k] != THR && next_cnt(k) == THR) r = 1;
      return r;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exp_hit <= '0;
         exp_obe <= 1'b0;
         exp_irq <= 1'b0;
         for (int k = 0; k < 4; k++) exp_cnt[k] <= 0;
      end else begin
         exp_hit <= hit_vec();
         exp_obe <= any_write_hit();
         exp_irq <= reaches_thr() ? 1'b1 : (irq_ack ? 1'b0 : exp_irq);
         for (int k = 0; k < 4; k++) exp_cnt[k] <= next_cnt(k);
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 0;
   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (hit !== exp_hit) begin errors++; $display("FAIL cyc_hit t=%0t got %b expected %b", $time, hit, exp_hit); end
         checks++;
         if (out_byte_en !== exp_obe) begin errors++; $display("FAIL cyc_obe t=%0t got %b expected %b", $time, out_byte_en, exp_obe); end
         checks++;
         if (irq !== exp_irq) begin errors++; $display("FAIL cyc_irq t=%0t got %b expected %b", $time, irq, exp_irq); end
         checks++;
         if (int'(cnt_val) != exp_cnt[cnt_sel] || $isunknown(cnt_val)) begin
            errors++; $display("FAIL cyc_cnt t=%0t sel=%0d got %0d expected %0d", $time, cnt_sel, cnt_val, exp_cnt[cnt_sel]);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("check %s: %0h ok", name, act);
      end
   endtask

   // Apply one bus cycle's inputs just after a rising edge.
   task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic c, input logic ack);
      @(posedge clk); #2;
      mem_la_write = w; mem_la_read = r; mem_la_addr = a; clr = c; irq_ack = ack;
   endtask

   task automatic idle_then_sample();
      drive(0, 0, 32'h0, 0, 0);
      @(negedge clk); #1;
   endtask

   logic [31:0] pick [13] = '{32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000, 32'h2FFF, 32'h3000,
                              32'h3FFF, 32'h4000, 32'h5000, 32'h7FFF, 32'h8000, 32'h8FFF, 32'h9000};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises;
      bit prev;
      resetn = 0; mem_la_write = 0; mem_la_read = 0; mem_la_addr = '0;
      clr = 0; irq_ack = 0; cnt_sel = 0;
      #12;
      chk("reset_hit", {28'h0, hit}, 32'h0);
      chk("reset_obe", {31'h0, out_byte_en}, 32'h0);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      chk("reset_cnt", {28'h0, cnt_val}, 32'h0);
      @(posedge clk); #2; resetn = 1;
      cmp_en = 1;

      // Write at window-0 base hits; write at its exclusive limit does not.
      drive(1, 0, 32'h1000, 0, 0); idle_then_sample();
      chk("wr_base_hit", {28'h0, hit}, 32'h1);
      chk("wr_base_obe", {31'h0, out_byte_en}, 32'h1);
      chk("wr_base_cnt0", {28'h0, cnt_val}, 32'h1);
      drive(1, 0, 32'h4000, 0, 0); idle_then_sample();
      chk("wr_limit_hit", {28'h0, hit}, 32'h0);
      chk("wr_limit_obe", {31'h0, out_byte_en}, 32'h0);

      // Overlapping windows 0 and 1.
      drive(1, 0, 32'h2800, 0, 0); idle_then_sample();
      chk("overlap_hit", {28'h0, hit}, 32'h3);
      chk("overlap_cnt0", {28'h0, cnt_val}, 32'h2);
      cnt_sel = 1; #1;
      chk("overlap_cnt1", {28'h0, cnt_val}, 32'h1);

      // Disabled window never hits.
      drive(1, 0, 32'h5000, 0, 0); idle_then_sample();
      chk("disabled_hit", {28'h0, hit}, 32'h0);

      // Clear on the same edge as a hit: pulse shows, count does not.
      cnt_sel = 0;
      drive(1, 0, 32'h1000, 1, 0); idle_then_sample();
      chk("clr_hit", {28'h0, hit}, 32'h1);
      chk("clr_obe", {31'h0, out_byte_en}, 32'h1);
      chk("clr_cnt0", {28'h0, cnt_val}, 32'h0);
      cnt_sel = 1; #1;
      chk("clr_cnt1", {28'h0, cnt_val}, 32'h0);

      // Read to window 0.
      cnt_sel = 0;
      drive(0, 1, 32'h1000, 0, 0); idle_then_sample();
`ifdef ADDR_MON_READ_EN
      chk("rd_hit", {28'h0, hit}, 32'h1);
      chk("rd_cnt0", {28'h0, cnt_val}, 32'h1);
`else
      chk("rd_hit", {28'h0, hit}, 32'h0);
      chk("rd_cnt0", {28'h0, cnt_val}, 32'h0);
`endif
      chk("rd_obe", {31'h0, out_byte_en}, 32'h0);

      // Saturation and sticky interrupt: 20 writes after a clear.
      drive(0, 0, 32'h0, 1, 0);
      rises = 0; prev = irq;
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 32'h1000, 0, 0);
         if (irq && !prev) rises++;
         prev = irq;
      end
      idle_then_sample();
      if (irq && !prev) rises++;
      chk("sat_cnt0", {28'h0, cnt_val}, 32'hF);
      chk("sat_irq", {31'h0, irq}, 32'h1);
      chk("sat_irq_rises", rises, 32'h1);
      drive(0, 0, 32'h0, 0, 1); idle_then_sample();
      chk("ack_irq", {31'h0, irq}, 32'h0);
      for (int i = 0; i < 3; i++) drive(1, 0, 32'h1000, 0, 0);
      idle_then_sample();
      chk("post_ack_irq", {31'h0, irq}, 32'h0);
      chk("post_ack_cnt0", {28'h0, cnt_val}, 32'hF);

      // Randomized traffic, with an asynchronous reset in the middle.
      drive(0, 0, 32'h0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a;
         a = ($urandom % 5 == 0) ? $urandom : pick[$urandom % 13];
         drive($urandom % 2, $urandom % 2, a, ($urandom % 200) == 0, ($urandom % 6) == 0);
         cnt_sel = 2'($urandom % 4);
         if (i == 1500) begin
            #1; resetn = 0; #1;
            chk("async_rst_hit", {28'h0, hit}, 32'h0);
            chk("async_rst_obe", {31'h0, out_byte_en}, 32'h0);
            chk("async_rst_irq", {31'h0, irq}, 32'h0);
            chk("async_rst_cnt", {28'h0, cnt_val}, 32'h0);
         end
         if (i == 1504) begin
            mem_la_write = 0; mem_la_read = 0;
            #2; resetn = 1;
         end
         if (i == 1505) begin
            for (int s = 0; s < 4; s++) begin
               cnt_sel = 2'(s); #1;
               chk($sformatf("post_rst_cnt%0d", s), {28'h0, cnt_val}, 32'h0);
            end
         end
      end
      idle_then_sample();
      cmp_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
